// File: rtl/cpu_pkg.sv
// ============================================================================
// Package     : cpu_pkg
// Description : Shared ISA encodings and control-FSM state type for the 18-bit CPU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_ANDI = 4'h3;
  localparam logic [3:0] OP_NAND = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JUMP = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;
  localparam logic [1:0] ALU_NOR  = 2'b11;

  localparam logic [1:0] PC_SRC_PLUS1  = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_decoder.sv
// ============================================================================
// Module      : instr_decoder
// Description : Combinational opcode decoder for the control FSM.
//               CTRL_BRANCH_EN enables JUMP/BEQ; otherwise 1000/1001 are illegal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic [1:0] alu_control_o,
  output logic       alu_src_b_o,
  output logic       wb_src_o,
  output logic       is_mem_o,
  output logic       is_load_o,
  output logic       is_branch_o,
  output logic       is_jump_o,
  output logic       is_illegal_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    alu_src_b_o   = 1'b0;
    wb_src_o      = 1'b0;
    is_mem_o      = 1'b0;
    is_load_o     = 1'b0;
    is_branch_o   = 1'b0;
    is_jump_o     = 1'b0;
    is_illegal_o  = 1'b0;
    case (opcode_i)
      OP_ADD:  alu_control_o = ALU_ADD;
      OP_ADDI: begin
        alu_control_o = ALU_ADD;
        alu_src_b_o   = 1'b1;
      end
      OP_AND:  alu_control_o = ALU_AND;
      OP_ANDI: begin
        alu_control_o = ALU_AND;
        alu_src_b_o   = 1'b1;
      end
      OP_NAND: alu_control_o = ALU_NAND;
      OP_NOR:  alu_control_o = ALU_NOR;
      OP_LD: begin
        alu_src_b_o = 1'b1;
        wb_src_o    = 1'b1;
        is_mem_o    = 1'b1;
        is_load_o   = 1'b1;
      end
      OP_ST: begin
        alu_src_b_o = 1'b1;
        is_mem_o    = 1'b1;
      end
`ifdef CTRL_BRANCH_EN
      OP_JUMP: is_jump_o   = 1'b1;
      OP_BEQ:  is_branch_o = 1'b1;
`endif
      default: is_illegal_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_control_unit.sv
// ============================================================================
// Module      : cpu_control_unit
// Description : Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 18-bit CPU.
//               CTRL_BRANCH_EN enables JUMP/BEQ decoding and non-zero pc_src.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] instr,
  input  logic        mem_ready,
  input  logic        eq,
  output logic [1:0]  alu_control,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic        wb_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        illegal
);

  state_t     state_q, state_d;
  logic [3:0] opcode_q, opcode_d;

  logic [1:0] dec_alu_control;
  logic       dec_alu_src_b, dec_wb_src, dec_is_mem, dec_is_load;
  logic       dec_is_branch, dec_is_jump, dec_is_illegal;

  logic [1:0] ctl_alu_control, ctl_pc_src;
  logic       ctl_alu_src_b, ctl_reg_write, ctl_wb_src, ctl_mem_read;
  logic       ctl_mem_write, ctl_ir_write, ctl_pc_write, ctl_illegal;

  logic       unused_instr_bits;
  assign unused_instr_bits = ^instr[13:0];

  instr_decoder u_decoder (
    .opcode_i      (opcode_q),
    .alu_control_o (dec_alu_control),
    .alu_src_b_o   (dec_alu_src_b),
    .wb_src_o      (dec_wb_src),
    .is_mem_o      (dec_is_mem),
    .is_load_o     (dec_is_load),
    .is_branch_o   (dec_is_branch),
    .is_jump_o     (dec_is_jump),
    .is_illegal_o  (dec_is_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      opcode_q <= OP_ADD;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    opcode_d        = opcode_q;
    ctl_alu_control = ALU_ADD;
    ctl_alu_src_b   = 1'b0;
    ctl_reg_write   = 1'b0;
    ctl_wb_src      = 1'b0;
    ctl_mem_read    = 1'b0;
    ctl_mem_write   = 1'b0;
    ctl_ir_write    = 1'b0;
    ctl_pc_write    = 1'b0;
    ctl_pc_src      = PC_SRC_PLUS1;
    ctl_illegal     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ctl_mem_read = 1'b1;
        if (mem_ready) begin
          ctl_ir_write = 1'b1;
          ctl_pc_write = 1'b1;
          opcode_d     = instr[17:14];
          state_d      = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_FETCH;
        if (dec_is_illegal) begin
          ctl_illegal = 1'b1;
`ifdef CTRL_BRANCH_EN
        end else if (dec_is_jump) begin
          ctl_pc_write = 1'b1;
          ctl_pc_src   = PC_SRC_JUMP;
        end else if (dec_is_branch) begin
          if (eq) begin
            ctl_pc_write = 1'b1;
            ctl_pc_src   = PC_SRC_BRANCH;
          end
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ctl_alu_control = dec_alu_control;
        ctl_alu_src_b   = dec_alu_src_b;
        state_d         = dec_is_mem ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        // Address control is held for the whole access so the datapath sees a stable address.
        ctl_alu_control = ALU_ADD;
        ctl_alu_src_b   = 1'b1;
        ctl_mem_read    = dec_is_load;
        ctl_mem_write   = dec_is_mem & ~dec_is_load;
        if (mem_ready) begin
          state_d = dec_is_load ? ST_WB : ST_FETCH;
        end
      end
      ST_WB: begin
        ctl_alu_control = dec_alu_control;
        ctl_alu_src_b   = dec_alu_src_b;
        ctl_reg_write   = 1'b1;
        ctl_wb_src      = dec_wb_src;
        state_d         = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

`ifndef CTRL_BRANCH_EN
  logic unused_branch_inputs;
  assign unused_branch_inputs = eq ^ dec_is_jump ^ dec_is_branch;
`endif

  // Everything except mem_read is forced low while reset is held.
  assign alu_control = rst ? ALU_ADD : ctl_alu_control;
  assign alu_src_b   = ctl_alu_src_b & ~rst;
  assign reg_write   = ctl_reg_write & ~rst;
  assign wb_src      = ctl_wb_src    & ~rst;
  assign mem_read    = ctl_mem_read;
  assign mem_write   = ctl_mem_write & ~rst;
  assign ir_write    = ctl_ir_write  & ~rst;
  assign pc_write    = ctl_pc_write  & ~rst;
  assign pc_src      = rst ? PC_SRC_PLUS1 : ctl_pc_src;
  assign illegal     = ctl_illegal   & ~rst;

endmodule

`default_nettype wire
